reg_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one DATA_W-bit storage register (a bank of D flip-flops) between 4 requesters.
- Each requester raises req, receives a one-hot grant, and has its data written into the shared register; ack confirms each write.
- An optional hold input locks ownership for burst writes. A lock-timeout counter bounds how long one requester can keep the register.
- Sits between requester logic and the shared register; Q is the register's output to downstream logic.

---
 rtl/reg_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter that owns one shared data register,
// with per-owner burst lock and a bounded lock duration.
module reg_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [3:0]          req,
  input  logic [3:0]          hold,
  input  logic [4*DATA_W-1:0] wr_data,
  output logic [3:0]          grant,
  output logic [3:0]          ack,
  output logic [DATA_W-1:0]   Q,
  output logic [1:0]          owner,
  output logic                busy,
  output logic                timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [7:0] CntLast = 8'(MAX_LOCK - 1);

  state_t              state_q;
  logic [3:0]          grant_q;
  logic [3:0]          ack_q;
  logic [DATA_W-1:0]   q_q;
  logic [1:0]          owner_q;
  logic [1:0]          ptr_q;
  logic [7:0]          cnt_q;
  logic                timeout_q;

  logic [1:0]          win_d;
  logic                win_vld_d;
  logic [DATA_W-1:0]   lane_d;
  logic                own_req_d;
  logic                own_hold_d;
  logic [1:0]          nxt_ptr_d;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win_d     = ptr_q;
    win_vld_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_vld_d && req[ptr_q + 2'(k)]) begin
        win_d     = ptr_q + 2'(k);
        win_vld_d = 1'b1;
      end
    end
  end

  // Owner-side view of the inputs.
  always_comb begin
    lane_d     = wr_data[owner_q*DATA_W +: DATA_W];
    own_req_d  = req[owner_q];
    own_hold_d = hold[owner_q];
    nxt_ptr_d  = owner_q + 2'd1;
  end

  // Ownership FSM with registered grant/ack/Q/timeout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      ack_q     <= '0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            grant_q <= 4'b0001 << win_d;
            owner_q <= win_d;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (own_req_d) begin
            q_q   <= lane_d;
            ack_q <= 4'b0001 << owner_q;
          end
          if (own_req_d && own_hold_d) begin
            state_q <= LOCK;
            cnt_q   <= '0;
          end else begin
            grant_q <= '0;
            ptr_q   <= nxt_ptr_d;
            state_q <= IDLE;
          end
        end
        LOCK: begin
          if (!own_hold_d) begin
            grant_q <= '0;
            ptr_q   <= nxt_ptr_d;
            state_q <= IDLE;
          end else begin
            if (own_req_d) begin
              q_q   <= lane_d;
              ack_q <= 4'b0001 << owner_q;
            end
            if (cnt_q == CntLast) begin
              timeout_q <= 1'b1;
              grant_q   <= '0;
              ptr_q     <= nxt_ptr_d;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign ack     = ack_q;
  assign Q       = q_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Bench for reg_rr_arbiter: cycle model feeds a queue of
// expected outputs, popped and compared after each edge.
module tb_reg_rr_arbiter;

  localparam int W  = 8;
  localparam int ML = 6;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     req   = '0;
  logic [3:0]     hold  = '0;
  logic [4*W-1:0] wr    = '0;
  logic [3:0]     grant;
  logic [3:0]     ack;
  logic [W-1:0]   q;
  logic [1:0]     owner;
  logic           busy;
  logic           timeout;

  reg_rr_arbiter #(
    .DATA_W   (W),
    .MAX_LOCK (ML)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .req       (req),
    .hold      (hold),
    .wr_data   (wr),
    .grant     (grant),
    .ack       (ack),
    .Q         (q),
    .owner     (owner),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   g;
    logic [3:0]   a;
    logic [W-1:0] q;
    logic [1:0]   o;
    logic         b;
    logic         t;
  } exp_t;

  typedef enum int {M_IDLE, M_XFER, M_LOCK} mst_t;

  exp_t       sbq[$];
  mst_t       ms;
  int         mptr, mcnt, mown;
  logic [3:0] mg;
  logic [W-1:0] mq;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic set_lane(int i, logic [W-1:0] v);
    wr[i*W +: W] = v;
  endtask

  task automatic model_rst();
    ms = M_IDLE; mptr = 0; mcnt = 0;
    mown = 0; mg = '0; mq = '0;
  endtask

  task automatic m_release();
    mg = '0; mptr = (mown + 1) % 4; ms = M_IDLE;
  endtask

  // Predict the outputs visible after the coming edge.
  task automatic model_edge();
    exp_t e;
    logic [7:0] dbl;
    logic [7:0] rot;
    logic [W-1:0] lane;
    int j;
    e = '0;
    lane = wr[mown*W +: W];
    case (ms)
      M_IDLE: begin
        dbl = {req, req};
        rot = dbl >> mptr;
        j = -1;
        for (int b = 3; b >= 0; b--) if (rot[b]) j = b;
        if (j >= 0) begin
          mown = (mptr + j) % 4;
          mg = 4'b0001 << mown;
          ms = M_XFER;
        end
      end
      M_XFER: begin
        if (!req[mown]) m_release();
        else begin
          mq = lane; e.a[mown] = 1'b1;
          if (hold[mown]) begin ms = M_LOCK; mcnt = 0; end
          else m_release();
        end
      end
      default: begin
        if (!hold[mown]) m_release();
        else begin
          if (req[mown]) begin mq = lane; e.a[mown] = 1'b1; end
          if (mcnt == ML - 1) begin e.t = 1'b1; m_release(); end
          else mcnt++;
        end
      end
    endcase
    e.g = mg; e.q = mq; e.o = 2'(mown); e.b = (ms != M_IDLE);
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("grant",   grant,   e.g);
      chk("ack",     ack,     e.a);
      chk("q",       q,       e.q);
      chk("owner",   owner,   e.o);
      chk("busy",    busy,    e.b);
      chk("timeout", timeout, e.t);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_q"},     q,       0);
    chk({tag, "_grant"}, grant,   0);
    chk({tag, "_ack"},   ack,     0);
    chk({tag, "_busy"},  busy,    0);
    chk({tag, "_owner"}, owner,   0);
    chk({tag, "_to"},    timeout, 0);
  endtask

  // Assert reset between edges and check it acts at once.
  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1 chk_zero(tag);
    model_rst();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acnt;
    model_rst();
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    rst_n = 1'b1;

    // single request
    set_lane(1, 8'hA5);
    req = 4'b0010;
    step(); chk("t1_grant", grant, 4'b0010);
    step(); chk("t1_q", q, 8'hA5);
    chk("t1_ack", ack, 4'b0010);
    req = 4'b0000;
    step(); chk("t1_idle", {grant, busy, ack}, 0);
    chk("t1_owner", owner, 1);

    // all requesting, fresh pointer
    async_reset("rst2");
    for (int i = 0; i < 4; i++) set_lane(i, 8'(8'hC0 + i));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(); chk("t2_grant", grant, 4'b0001 << (i % 4));
      step(); chk("t2_q", q, 8'(8'hC0 + i % 4));
    end

    // burst lock on requester 2, 3 pending
    req = 4'b1100; hold = 4'b0100;
    set_lane(3, 8'h3C);
    set_lane(2, 8'h10);
    step(); chk("t3_grant", grant, 4'b0100);
    for (int v = 0; v < 6; v++) begin
      set_lane(2, 8'(8'h10 + v));
      step();
      chk("t3_q", q, 8'(8'h10 + v));
      chk("t3_ack", ack, 4'b0100);
    end
    hold = 4'b0000;
    step(); chk("t3_rel", {grant, ack, 3'(timeout)}, 0);
    step(); chk("t3_next", grant, 4'b1000);
    step(); chk("t3_q3", q, 8'h3C);
    req = 4'b0000;
    step();

    // lock timeout on requester 0, 1 pending
    set_lane(0, 8'h30); set_lane(1, 8'h31);
    req = 4'b0011; hold = 4'b0001;
    step(); chk("t4_grant", grant, 4'b0001);
    acnt = 0;
    for (int c = 0; c < ML + 1; c++) begin
      step();
      acnt += int'(ack[0]);
    end
    chk("t4_writes", acnt, ML + 1);
    chk("t4_to", timeout, 1);
    chk("t4_drop", grant, 0);
    step(); chk("t4_next", grant, 4'b0010);
    step(); chk("t4_q", q, 8'h31);
    req = 4'b0000; hold = 4'b0000;
    step();

    // withdrawn request from requester 3
    set_lane(3, 8'hEE);
    req = 4'b1000;
    step(); chk("t5_grant", grant, 4'b1000);
    req = 4'b0000;
    step(); chk("t5_ack", ack, 0);
    chk("t5_q", q, 8'h31);
    chk("t5_idle", {grant, busy}, 0);
    req = 4'b1111;
    step(); chk("t5_ptr", grant, 4'b0001);
    req = 4'b0000;
    step(); step();

    // reset in the middle of a burst
    set_lane(2, 8'h77);
    req = 4'b0100; hold = 4'b0100;
    step(); step(); step();
    chk("t6_lock", {busy, q}, {1'b1, 8'h77});
    async_reset("t6_rst");
    req = 4'b1111; hold = 4'b0000;
    step(); chk("t6_first", grant, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
